// File: rtl/vga_rect_writer_pkg.sv
// ---------------------------------------------------------------------------
// vga_rect_writer_pkg
//   Shared definitions for the rectangle-fill write engine that feeds the
//   write port of the dual-port video RAM.
//   Contents:
//     state_t        FSM encoding (IDLE / CLIP / FILL)
//     xmax_of/ymax_of  visible screen size for the selected resolution
//     xw_of/yw_of/aw_of  coordinate and address widths for that resolution
//     cw_of          colour word width from channel depth / monochrome mode
// ---------------------------------------------------------------------------
package vga_rect_writer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLIP = 2'd1,
        FILL = 2'd2
    } state_t;

    // Visible width in dots.
    function automatic int xmax_of(input bit low_res);
        return low_res ? 160 : 320;
    endfunction

    // Visible height in lines.
    function automatic int ymax_of(input bit low_res);
        return low_res ? 120 : 240;
    endfunction

    // Bits needed for an x coordinate (0 .. XMAX-1).
    function automatic int xw_of(input bit low_res);
        return low_res ? 8 : 9;
    endfunction

    // Bits needed for a y coordinate (0 .. YMAX-1).
    function automatic int yw_of(input bit low_res);
        return low_res ? 7 : 8;
    endfunction

    // Bits needed for a linear video RAM address (0 .. XMAX*YMAX-1).
    function automatic int aw_of(input bit low_res);
        return low_res ? 15 : 17;
    endfunction

    // Colour word width: one bit in monochrome, otherwise three channels.
    function automatic int cw_of(input bit mono, input int bits_per_channel);
        return mono ? 1 : 3 * bits_per_channel;
    endfunction

endpackage

// File: rtl/vga_rect_writer_address_translator.sv
// ---------------------------------------------------------------------------
// vga_rect_writer_address_translator
//   Purely combinational (x, y) -> linear video RAM address converter,
//   address = y * XMAX + x. Shared by the fill engine so the multiply exists
//   exactly once.
//   Ports:
//     x        in   XW   column
//     y        in   YW   row
//     address  out  AW   linear address into the video RAM
// ---------------------------------------------------------------------------
module vga_rect_writer_address_translator
    import vga_rect_writer_pkg::*;
#(
    parameter int XW   = xw_of(1'b0),
    parameter int YW   = yw_of(1'b0),
    parameter int AW   = aw_of(1'b0),
    parameter int XMAX = xmax_of(1'b0)
)(
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    output logic [AW-1:0] address
);

    // XMAX is a constant, so the product reduces to shifts and adds in
    // synthesis (320 = 256 + 64, 160 = 128 + 32).
    assign address = AW'(y) * AW'(XMAX) + AW'(x);

endmodule

// File: rtl/vga_rect_writer.sv
// ---------------------------------------------------------------------------
// vga_rect_writer
//   Rectangle-fill engine for the VGA video memory. Accepts one fill command
//   per valid/ready handshake, clips it against the right and bottom screen
//   edges and then emits one video RAM write per clock in raster order.
//   Ports:
//     clock        in   1    system clock, everything on posedge
//     reset        in   1    synchronous, active-high
//     req_valid    in   1    command valid
//     req_ready    out  1    high only while idle
//     req_x/req_y  in   XW/YW  top-left corner of the rectangle
//     req_w/req_h  in   XW/YW  size in dots (0 = empty command)
//     req_color    in   CW   fill colour
//     mem_address  out  AW   video RAM write address (y*XMAX + x)
//     mem_data     out  CW   video RAM write data
//     mem_wren     out  1    write strobe, one dot per high cycle
//     busy         out  1    high while clipping or filling
//     done         out  1    one-cycle pulse when a command completes
// ---------------------------------------------------------------------------
module vga_rect_writer
    import vga_rect_writer_pkg::*;
#(
    parameter int    BITS_PER_COLOR_CHANNEL = 1,
    parameter string MONOCHROME             = "FALSE",
    parameter string RESOLUTION             = "320x240",
    localparam bit   LOW_RES = (RESOLUTION == "160x120"),
    localparam bit   MONO    = (MONOCHROME == "TRUE"),
    localparam int   XMAX    = xmax_of(LOW_RES),
    localparam int   YMAX    = ymax_of(LOW_RES),
    localparam int   XW      = xw_of(LOW_RES),
    localparam int   YW      = yw_of(LOW_RES),
    localparam int   AW      = aw_of(LOW_RES),
    localparam int   CW      = cw_of(MONO, BITS_PER_COLOR_CHANNEL)
)(
    input  logic          clock,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [XW-1:0] req_x,
    input  logic [YW-1:0] req_y,
    input  logic [XW-1:0] req_w,
    input  logic [YW-1:0] req_h,
    input  logic [CW-1:0] req_color,
    output logic [AW-1:0] mem_address,
    output logic [CW-1:0] mem_data,
    output logic          mem_wren,
    output logic          busy,
    output logic          done
);

    // Screen limits widened by one bit so x+w / y+h never overflow when
    // compared against them.
    localparam logic [XW:0] X_LIMIT = (XW+1)'(XMAX);
    localparam logic [YW:0] Y_LIMIT = (YW+1)'(YMAX);

    state_t        state_q,       state_d;
    logic [XW-1:0] x_q,           x_d;
    logic [YW-1:0] y_q,           y_d;
    logic [XW-1:0] w_q,           w_d;
    logic [YW-1:0] h_q,           h_d;
    logic [CW-1:0] color_q,       color_d;
    logic [XW-1:0] x_end_q,       x_end_d;
    logic [YW-1:0] y_end_q,       y_end_d;
    logic [XW-1:0] cur_x_q,       cur_x_d;
    logic [YW-1:0] cur_y_q,       cur_y_d;
    logic [AW-1:0] mem_address_q, mem_address_d;
    logic [CW-1:0] mem_data_q,    mem_data_d;
    logic          mem_wren_q,    mem_wren_d;
    logic          done_q,        done_d;

    logic [XW:0]   x_sum;
    logic [XW:0]   x_lim;
    logic [XW:0]   x_last;
    logic [YW:0]   y_sum;
    logic [YW:0]   y_lim;
    logic [YW:0]   y_last;
    logic [XW-1:0] clip_x_end;
    logic [YW-1:0] clip_y_end;
    logic          is_empty;

    logic [XW-1:0] nxt_x;
    logic [YW-1:0] nxt_y;
    logic [AW-1:0] nxt_address;

    // Clip the captured command against the right and bottom edges. When the
    // command turns out empty the end coordinates may wrap, but they are
    // never used in that case.
    always_comb begin
        x_sum      = {1'b0, x_q} + {1'b0, w_q};
        y_sum      = {1'b0, y_q} + {1'b0, h_q};
        x_lim      = (x_sum > X_LIMIT) ? X_LIMIT : x_sum;
        y_lim      = (y_sum > Y_LIMIT) ? Y_LIMIT : y_sum;
        x_last     = x_lim - 1'b1;
        y_last     = y_lim - 1'b1;
        clip_x_end = x_last[XW-1:0];
        clip_y_end = y_last[YW-1:0];
        is_empty   = (w_q == '0) || (h_q == '0) ||
                     ({1'b0, x_q} >= X_LIMIT) || ({1'b0, y_q} >= Y_LIMIT);
    end

    // Next dot in raster order. Leaving CLIP the first dot is the top-left
    // corner; inside FILL the cursor steps right and wraps to the start
    // column of the next row at the clipped right edge.
    always_comb begin
        nxt_x = cur_x_q;
        nxt_y = cur_y_q;
        if (state_q == CLIP) begin
            nxt_x = x_q;
            nxt_y = y_q;
        end else if (cur_x_q == x_end_q) begin
            nxt_x = x_q;
            nxt_y = cur_y_q + 1'b1;
        end else begin
            nxt_x = cur_x_q + 1'b1;
        end
    end

    vga_rect_writer_address_translator #(
        .XW   (XW),
        .YW   (YW),
        .AW   (AW),
        .XMAX (XMAX)
    ) u_translator (
        .x       (nxt_x),
        .y       (nxt_y),
        .address (nxt_address)
    );

    // FSM next-state and registered-output logic. The write strobe and done
    // pulse default low so they only last one cycle unless re-asserted;
    // address and data hold their last value between writes.
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        w_d           = w_q;
        h_d           = h_q;
        color_d       = color_q;
        x_end_d       = x_end_q;
        y_end_d       = y_end_q;
        cur_x_d       = cur_x_q;
        cur_y_d       = cur_y_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        mem_wren_d    = 1'b0;
        done_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    x_d     = req_x;
                    y_d     = req_y;
                    w_d     = req_w;
                    h_d     = req_h;
                    color_d = req_color;
                    state_d = CLIP;
                end
            end

            CLIP: begin
                x_end_d = clip_x_end;
                y_end_d = clip_y_end;
                if (is_empty) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cur_x_d       = nxt_x;
                    cur_y_d       = nxt_y;
                    mem_address_d = nxt_address;
                    mem_data_d    = color_q;
                    mem_wren_d    = 1'b1;
                    state_d       = FILL;
                end
            end

            FILL: begin
                // The bottom-right dot has already been presented, so this
                // edge only closes the command.
                if ((cur_x_q == x_end_q) && (cur_y_q == y_end_q)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cur_x_d       = nxt_x;
                    cur_y_d       = nxt_y;
                    mem_address_d = nxt_address;
                    mem_wren_d    = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any command in flight
    // without a done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            w_q           <= '0;
            h_q           <= '0;
            color_q       <= '0;
            x_end_q       <= '0;
            y_end_q       <= '0;
            cur_x_q       <= '0;
            cur_y_q       <= '0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_wren_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            w_q           <= w_d;
            h_q           <= h_d;
            color_q       <= color_d;
            x_end_q       <= x_end_d;
            y_end_q       <= y_end_d;
            cur_x_q       <= cur_x_d;
            cur_y_q       <= cur_y_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            mem_wren_q    <= mem_wren_d;
            done_q        <= done_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign mem_wren    = mem_wren_q;
    assign done        = done_q;

endmodule

// File: tb/tb_vga_rect_writer.sv
// ---------------------------------------------------------------------------
// tb_vga_rect_writer
//   Bench for vga_rect_writer. Two instances: dut_hi (320x240, 3-bit colour)
//   and dut_lo (160x120, monochrome). Each directed command pushes its
//   hand-computed writes and done pulse, tagged with the cycle they must
//   appear on, into a per-instance queue; a monitor pops them as the
//   instance presents mem_wren or done.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_rect_writer;

    logic clock = 1'b0;
    logic reset;
    int   cyc   = 0;

    // 100 MHz clock and a running edge counter used to time expectations.
    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
    end

    // 320x240, 3-bit colour instance signals.
    logic        hi_req_valid;
    logic        hi_req_ready;
    logic [8:0]  hi_req_x;
    logic [7:0]  hi_req_y;
    logic [8:0]  hi_req_w;
    logic [7:0]  hi_req_h;
    logic [2:0]  hi_req_color;
    logic [16:0] hi_mem_address;
    logic [2:0]  hi_mem_data;
    logic        hi_mem_wren;
    logic        hi_busy;
    logic        hi_done;

    // 160x120 monochrome instance signals.
    logic        lo_req_valid;
    logic        lo_req_ready;
    logic [7:0]  lo_req_x;
    logic [6:0]  lo_req_y;
    logic [7:0]  lo_req_w;
    logic [6:0]  lo_req_h;
    logic [0:0]  lo_req_color;
    logic [14:0] lo_mem_address;
    logic [0:0]  lo_mem_data;
    logic        lo_mem_wren;
    logic        lo_busy;
    logic        lo_done;

    vga_rect_writer dut_hi (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (hi_req_valid),
        .req_ready   (hi_req_ready),
        .req_x       (hi_req_x),
        .req_y       (hi_req_y),
        .req_w       (hi_req_w),
        .req_h       (hi_req_h),
        .req_color   (hi_req_color),
        .mem_address (hi_mem_address),
        .mem_data    (hi_mem_data),
        .mem_wren    (hi_mem_wren),
        .busy        (hi_busy),
        .done        (hi_done)
    );

    vga_rect_writer #(
        .RESOLUTION ("160x120"),
        .MONOCHROME ("TRUE")
    ) dut_lo (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (lo_req_valid),
        .req_ready   (lo_req_ready),
        .req_x       (lo_req_x),
        .req_y       (lo_req_y),
        .req_w       (lo_req_w),
        .req_h       (lo_req_h),
        .req_color   (lo_req_color),
        .mem_address (lo_mem_address),
        .mem_data    (lo_mem_data),
        .mem_wren    (lo_mem_wren),
        .busy        (lo_busy),
        .done        (lo_done)
    );

    // Uniform views of both instances for the monitor.
    logic [16:0] m_addr [2];
    logic [2:0]  m_data [2];
    logic        m_wren [2];
    logic        m_done [2];

    assign m_addr[0] = hi_mem_address;
    assign m_addr[1] = {2'b00, lo_mem_address};
    assign m_data[0] = hi_mem_data;
    assign m_data[1] = {2'b00, lo_mem_data};
    assign m_wren[0] = hi_mem_wren;
    assign m_wren[1] = lo_mem_wren;
    assign m_done[0] = hi_done;
    assign m_done[1] = lo_done;

    typedef struct {
        bit is_done;
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t exp_q [2][$];
    int   compared   = 0;
    int   mismatched = 0;

    // Single comparison point used by the monitor and the direct checks.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic expectWrite(input int dut, input int c, input int a, input int d);
        exp_t e;
        e.is_done = 1'b0;
        e.addr    = a;
        e.data    = d;
        e.cyc     = c;
        exp_q[dut].push_back(e);
    endtask

    task automatic expectDone(input int dut, input int c);
        exp_t e;
        e.is_done = 1'b1;
        e.addr    = 0;
        e.data    = 0;
        e.cyc     = c;
        exp_q[dut].push_back(e);
    endtask

    // Pops one expectation per presented write or done pulse.
    task automatic monitorPort(input int i);
        exp_t e;
        if (m_wren[i] === 1'b1 || m_done[i] === 1'b1) begin
            if (exp_q[i].size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL dut%0d unexpected output: wren=%0b done=%0b addr=%0d at cycle %0d, expected none",
                         i, m_wren[i], m_done[i], m_addr[i], cyc);
            end else begin
                e = exp_q[i].pop_front();
                checkOutput($sformatf("dut%0d event cycle", i), cyc, e.cyc);
                if (e.is_done) begin
                    checkOutput($sformatf("dut%0d done", i), 32'(m_done[i]), 32'd1);
                    checkOutput($sformatf("dut%0d wren in done", i), 32'(m_wren[i]), 32'd0);
                end else begin
                    checkOutput($sformatf("dut%0d wren", i), 32'(m_wren[i]), 32'd1);
                    checkOutput($sformatf("dut%0d address", i), 32'(m_addr[i]), e.addr);
                    checkOutput($sformatf("dut%0d data", i), 32'(m_data[i]), e.data);
                    checkOutput($sformatf("dut%0d done in write", i), 32'(m_done[i]), 32'd0);
                end
            end
        end
    endtask

    always begin
        @(posedge clock);
        #1;
        for (int i = 0; i < 2; i++) begin
            monitorPort(i);
        end
    end

    // Issues one command on the next falling edge; acc is the edge number
    // that accepts it. Returns one cycle later with valid dropped.
    task automatic applyStimulus(input int dut, input int x, input int y, input int w,
                                 input int h, input int c, output int acc);
        @(negedge clock);
        if (dut == 0) begin
            hi_req_valid = 1'b1;
            hi_req_x     = 9'(x);
            hi_req_y     = 8'(y);
            hi_req_w     = 9'(w);
            hi_req_h     = 8'(h);
            hi_req_color = 3'(c);
        end else begin
            lo_req_valid = 1'b1;
            lo_req_x     = 8'(x);
            lo_req_y     = 7'(y);
            lo_req_w     = 8'(w);
            lo_req_h     = 7'(h);
            lo_req_color = 1'(c);
        end
        acc = cyc + 1;
        @(negedge clock);
        hi_req_valid = 1'b0;
        lo_req_valid = 1'b0;
    endtask

    // Waits for every queued expectation to be consumed, bounded.
    task automatic waitDrain(input int dut, input int budget);
        int n;
        n = 0;
        while (exp_q[dut].size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (exp_q[dut].size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL dut%0d drain timeout: %0d events outstanding, expected 0",
                     dut, exp_q[dut].size());
            exp_q[dut].delete();
        end
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int acc;

        reset        = 1'b1;
        hi_req_valid = 1'b0;
        hi_req_x     = '0;
        hi_req_y     = '0;
        hi_req_w     = '0;
        hi_req_h     = '0;
        hi_req_color = '0;
        lo_req_valid = 1'b0;
        lo_req_x     = '0;
        lo_req_y     = '0;
        lo_req_w     = '0;
        lo_req_h     = '0;
        lo_req_color = '0;

        // Reset held for three edges.
        repeat (3) @(negedge clock);
        checkOutput("reset req_ready", 32'(hi_req_ready), 32'd1);
        checkOutput("reset mem_wren", 32'(hi_mem_wren), 32'd0);
        checkOutput("reset busy", 32'(hi_busy), 32'd0);
        checkOutput("reset done", 32'(hi_done), 32'd0);
        checkOutput("reset mem_address", 32'(hi_mem_address), 32'd0);
        checkOutput("reset mem_data", 32'(hi_mem_data), 32'd0);
        checkOutput("reset lo req_ready", 32'(lo_req_ready), 32'd1);
        checkOutput("reset lo busy", 32'(lo_busy), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        $display("[TB] 2x2 fill at (10,5)");
        applyStimulus(0, 10, 5, 2, 2, 5, acc);
        expectWrite(0, acc + 1, 1610, 5);
        expectWrite(0, acc + 2, 1611, 5);
        expectWrite(0, acc + 3, 1930, 5);
        expectWrite(0, acc + 4, 1931, 5);
        expectDone(0, acc + 5);
        waitDrain(0, 20);

        $display("[TB] clipped fill at (318,238)");
        applyStimulus(0, 318, 238, 10, 10, 2, acc);
        expectWrite(0, acc + 1, 76478, 2);
        expectWrite(0, acc + 2, 76479, 2);
        expectWrite(0, acc + 3, 76798, 2);
        expectWrite(0, acc + 4, 76799, 2);
        expectDone(0, acc + 5);
        waitDrain(0, 20);

        $display("[TB] exact fit against right edge");
        applyStimulus(0, 316, 0, 4, 1, 3, acc);
        expectWrite(0, acc + 1, 316, 3);
        expectWrite(0, acc + 2, 317, 3);
        expectWrite(0, acc + 3, 318, 3);
        expectWrite(0, acc + 4, 319, 3);
        expectDone(0, acc + 5);
        waitDrain(0, 20);

        $display("[TB] single dot on bottom row");
        applyStimulus(0, 0, 239, 1, 1, 4, acc);
        expectWrite(0, acc + 1, 76480, 4);
        expectDone(0, acc + 2);
        waitDrain(0, 20);

        $display("[TB] empty commands");
        applyStimulus(0, 5, 5, 0, 3, 7, acc);
        expectDone(0, acc + 1);
        waitDrain(0, 10);
        applyStimulus(0, 320, 0, 4, 4, 7, acc);
        expectDone(0, acc + 1);
        waitDrain(0, 10);
        applyStimulus(0, 0, 0, 3, 0, 7, acc);
        expectDone(0, acc + 1);
        waitDrain(0, 10);
        applyStimulus(0, 0, 240, 2, 2, 7, acc);
        expectDone(0, acc + 1);
        waitDrain(0, 10);

        $display("[TB] reset during fill");
        applyStimulus(0, 0, 0, 4, 4, 6, acc);
        expectWrite(0, acc + 1, 0, 6);
        expectWrite(0, acc + 2, 1, 6);
        expectWrite(0, acc + 3, 2, 6);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("abort mem_wren", 32'(hi_mem_wren), 32'd0);
        checkOutput("abort done", 32'(hi_done), 32'd0);
        checkOutput("abort req_ready", 32'(hi_req_ready), 32'd1);
        checkOutput("abort busy", 32'(hi_busy), 32'd0);
        checkOutput("abort mem_address", 32'(hi_mem_address), 32'd0);
        reset = 1'b0;
        waitDrain(0, 5);
        repeat (6) @(negedge clock);

        $display("[TB] second command held during first");
        @(negedge clock);
        hi_req_valid = 1'b1;
        hi_req_x     = 9'd20;
        hi_req_y     = 8'd10;
        hi_req_w     = 9'd3;
        hi_req_h     = 8'd1;
        hi_req_color = 3'd3;
        acc          = cyc + 1;
        @(negedge clock);
        hi_req_x     = 9'd0;
        hi_req_y     = 8'd0;
        hi_req_w     = 9'd1;
        hi_req_h     = 8'd1;
        hi_req_color = 3'd7;
        expectWrite(0, acc + 1, 3220, 3);
        expectWrite(0, acc + 2, 3221, 3);
        expectWrite(0, acc + 3, 3222, 3);
        expectDone(0, acc + 4);
        expectWrite(0, acc + 6, 0, 7);
        expectDone(0, acc + 7);
        @(negedge clock);
        checkOutput("fill busy", 32'(hi_busy), 32'd1);
        checkOutput("fill req_ready", 32'(hi_req_ready), 32'd0);
        repeat (3) @(negedge clock);
        checkOutput("done-cycle req_ready", 32'(hi_req_ready), 32'd1);
        @(negedge clock);
        hi_req_valid = 1'b0;
        waitDrain(0, 20);

        $display("[TB] 160x120 monochrome instance");
        applyStimulus(1, 159, 119, 5, 5, 1, acc);
        expectWrite(1, acc + 1, 19199, 1);
        expectDone(1, acc + 2);
        waitDrain(1, 20);
        applyStimulus(1, 0, 0, 2, 2, 1, acc);
        expectWrite(1, acc + 1, 0, 1);
        expectWrite(1, acc + 2, 1, 1);
        expectWrite(1, acc + 3, 160, 1);
        expectWrite(1, acc + 4, 161, 1);
        expectDone(1, acc + 5);
        waitDrain(1, 20);

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
